// File: rtl/cart_bus_arbiter.sv
// Sequenced req/ack arbiter sharing one cart_iface port between NREQ requesters.
// Define CART_ARB_RR_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module cart_bus_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_8m,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [16*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_mask,
  output logic [NREQ-1:0]   ack,
  output logic              ack_err,
  output logic [7:0]        rdata,
  output logic [1:0]        owner,
  output logic              bus_active,
  output logic [15:0]       cart_addr,
  output logic              cart_rd,
  output logic              cart_wr,
  output logic [7:0]        cart_din,
  input  logic [7:0]        cart_dout,
  input  logic              cart_busy,
  output logic [2:0]        dbg_state
);

  // Handshake: a requester holds req/addr/wdata/wr stable until it sees its
  // one-cycle ack bit; ack_err and rdata are valid in that same cycle. Once
  // granted, the transaction always completes even if req is dropped.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_WAIT_FALL = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t          state;
  logic            wr_q;
  logic            err_q;
  logic            rise_cnt;
  logic [7:0]      tmo_cnt;
  logic [NREQ-1:0] eligible;
  logic [1:0]      win;
  logic            win_vld;
  logic            tmo_hit;

`ifdef CART_ARB_RR_EN
  logic [1:0] last_q;
`endif

  assign dbg_state = state;

  // Fires on the edge that enters DONE so the ack lands TIMEOUT cycles after grant.
  assign tmo_hit = ({1'b0, tmo_cnt} + 9'd2) >= 9'(TIMEOUT);

  always_comb begin
    eligible = req & req_mask;
    win      = '0;
    win_vld  = 1'b0;
`ifdef CART_ARB_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(last_q) + 1 + k) % NREQ;
      if (!win_vld && eligible[idx]) begin
        win     = 2'(idx);
        win_vld = 1'b1;
      end
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win     = 2'(i);
        win_vld = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ack        <= '0;
      ack_err    <= 1'b0;
      rdata      <= 8'h00;
      owner      <= 2'd0;
      bus_active <= 1'b0;
      cart_addr  <= 16'h0000;
      cart_din   <= 8'h00;
      cart_rd    <= 1'b0;
      cart_wr    <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      rise_cnt   <= 1'b0;
      tmo_cnt    <= 8'd0;
`ifdef CART_ARB_RR_EN
      last_q     <= 2'(NREQ - 1);
`endif
    end else begin
      cart_rd <= 1'b0;
      cart_wr <= 1'b0;
      ack     <= '0;
      ack_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            owner      <= win;
            cart_addr  <= req_addr[16*win +: 16];
            cart_din   <= req_wdata[8*win +: 8];
            wr_q       <= req_wr[win];
            cart_rd    <= !req_wr[win];
            cart_wr    <= req_wr[win];
            bus_active <= 1'b1;
            tmo_cnt    <= 8'd0;
            err_q      <= 1'b0;
            rise_cnt   <= 1'b0;
            state      <= S_ISSUE;
`ifdef CART_ARB_RR_EN
            last_q     <= win;
`endif
          end
        end
        S_ISSUE: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          state   <= S_WAIT_RISE;
        end
        S_WAIT_RISE: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (cart_busy) begin
            state <= S_WAIT_FALL;
          end else if (rise_cnt) begin
            // Busy never rose: zero-wait responder, data is already on dout.
            if (!wr_q) rdata <= cart_dout;
            state <= S_DONE;
          end else begin
            rise_cnt <= 1'b1;
          end
        end
        S_WAIT_FALL: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (!cart_busy) begin
            if (!wr_q) rdata <= cart_dout;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          ack[owner] <= 1'b1;
          ack_err    <= err_q;
          bus_active <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter with a small cart_iface responder model.
// Expected values are hand-computed from the transaction timing.
module tb_cart_bus_arbiter;

  logic        clk_8m;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  req_wr;
  logic [47:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  req_mask;
  logic [2:0]  ack;
  logic        ack_err;
  logic [7:0]  rdata;
  logic [1:0]  owner;
  logic        bus_active;
  logic [15:0] cart_addr;
  logic        cart_rd;
  logic        cart_wr;
  logic [7:0]  cart_din;
  logic [7:0]  cart_dout;
  logic        cart_busy;
  logic [2:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  cart_bus_arbiter #(.NREQ(3), .TIMEOUT(20)) dut (
    .clk_8m(clk_8m), .rst_n(rst_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .ack(ack), .ack_err(ack_err), .rdata(rdata), .owner(owner),
    .bus_active(bus_active), .cart_addr(cart_addr), .cart_rd(cart_rd),
    .cart_wr(cart_wr), .cart_din(cart_din), .cart_dout(cart_dout),
    .cart_busy(cart_busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk_8m = 1'b0;
  always #5 clk_8m = ~clk_8m;

  // cart responder: mode 0 = busy 3 cycles after a 1-cycle delay, 1 = zero-wait, 2 = stuck busy
  int         busy_mode = 0;
  logic       pend;
  logic [1:0] busy_left;
  int         rd_cnt = 0;
  int         wr_cnt = 0;

  always @(posedge clk_8m) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      cart_busy <= 1'b0;
      busy_left <= 2'd0;
    end else begin
      pend <= 1'b0;
      if (pend) begin
        cart_busy <= 1'b1;
        busy_left <= 2'd2;
      end else if (cart_busy && busy_mode == 0) begin
        if (busy_left == 2'd0) cart_busy <= 1'b0;
        else busy_left <= busy_left - 2'd1;
      end
      if ((cart_rd || cart_wr) && busy_mode != 1) pend <= 1'b1;
    end
  end

  always @(posedge clk_8m) begin
    if (cart_rd) rd_cnt <= rd_cnt + 1;
    if (cart_wr) wr_cnt <= wr_cnt + 1;
  end

  // hold checker: cart_addr/cart_din must match the granted request while bus_active
  logic        track = 1'b0;
  logic [15:0] exp_addr = '0;
  logic [7:0]  exp_din = '0;
  int          hold_bad = 0;

  always @(negedge clk_8m) begin
    if (track && bus_active && (cart_addr !== exp_addr || cart_din !== exp_din))
      hold_bad <= hold_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic start(input int idx, input logic wr, input logic [15:0] a, input logic [7:0] d);
    req = '0;
    req_wr = '0;
    req[idx] = 1'b1;
    req_wr[idx] = wr;
    req_addr[16*idx +: 16] = a;
    req_wdata[8*idx +: 8] = d;
    exp_addr = a;
    exp_din = d;
  endtask

  task automatic wait_ack(output int lat, output logic [2:0] a, output logic e, output logic ba);
    lat = -1;
    a = '0;
    e = 1'b0;
    ba = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_8m);
      if (ack != 3'b000) begin
        lat = n - 1;
        a = ack;
        e = ack_err;
        ba = bus_active;
        return;
      end
    end
    check("ack_seen", 32'd0, 32'd1);
  endtask

  int         lat;
  logic [2:0] a;
  logic       e;
  logic       ba;
  int         rd0, wr0, hb0;
  logic [2:0] exp_cont [3];

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    req_mask = 3'b111;
    cart_dout = 8'h00;
`ifdef CART_ARB_RR_EN
    exp_cont[0] = 3'b010; exp_cont[1] = 3'b100; exp_cont[2] = 3'b001;
`else
    exp_cont[0] = 3'b001; exp_cont[1] = 3'b001; exp_cont[2] = 3'b001;
`endif
    repeat (3) @(negedge clk_8m);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_bus_active", 32'(bus_active), 32'd0);
    check("rst_cart_rd", 32'(cart_rd), 32'd0);
    check("rst_cart_wr", 32'(cart_wr), 32'd0);
    check("rst_cart_addr", 32'(cart_addr), 32'd0);
    check("rst_cart_din", 32'(cart_din), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_8m);

    // single read, busy 3 cycles
    busy_mode = 0;
    cart_dout = 8'h4E;
    track = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt; hb0 = hold_bad;
    start(1, 1'b0, 16'h0134, 8'h11);
    wait_ack(lat, a, e, ba);
    req = '0;
    check("rd_latency", 32'(lat), 32'd7);
    check("rd_ack", 32'(a), 32'b010);
    check("rd_ack_err", 32'(e), 32'd0);
    check("rd_rdata", 32'(rdata), 32'h4E);
    check("rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("rd_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("rd_hold", 32'(hold_bad - hb0), 32'd0);
    check("rd_owner", 32'(owner), 32'd1);

    // write: rdata untouched, din held
    cart_dout = 8'h77;
    rd0 = rd_cnt; wr0 = wr_cnt; hb0 = hold_bad;
    start(2, 1'b1, 16'h2000, 8'h05);
    wait_ack(lat, a, e, ba);
    req = '0;
    check("wr_latency", 32'(lat), 32'd7);
    check("wr_ack", 32'(a), 32'b100);
    check("wr_pulses", 32'(wr_cnt - wr0), 32'd1);
    check("wr_no_rd", 32'(rd_cnt - rd0), 32'd0);
    check("wr_rdata_kept", 32'(rdata), 32'h4E);
    check("wr_hold", 32'(hold_bad - hb0), 32'd0);
    check("wr_owner", 32'(owner), 32'd2);

    // zero-wait read
    busy_mode = 1;
    cart_dout = 8'hA5;
    start(0, 1'b0, 16'h0010, 8'h00);
    wait_ack(lat, a, e, ba);
    req = '0;
    check("zw_latency", 32'(lat), 32'd4);
    check("zw_ack", 32'(a), 32'b001);
    check("zw_rdata", 32'(rdata), 32'hA5);

    // contention, all requesters held
    busy_mode = 0;
    cart_dout = 8'h3C;
    track = 1'b0;
    req_wr = '0;
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_ack(lat, a, e, ba);
      check("cont_ack", 32'(a), 32'(exp_cont[k]));
      check("cont_gap", 32'(ba), 32'd0);
    end
    req = '0;

    // masking
    req = 3'b011;
    req_mask = 3'b010;
    for (int k = 0; k < 2; k++) begin
      wait_ack(lat, a, e, ba);
      check("mask_ack", 32'(a), 32'b010);
    end
    req_mask = 3'b011;
    wait_ack(lat, a, e, ba);
    check("unmask_ack", 32'(a), 32'b001);
    req = '0;
    req_mask = 3'b111;
    check("mask_rdata", 32'(rdata), 32'h3C);

    // timeout with busy stuck high
    busy_mode = 2;
    cart_dout = 8'h99;
    track = 1'b1;
    hb0 = hold_bad;
    start(1, 1'b0, 16'h0456, 8'h00);
    wait_ack(lat, a, e, ba);
    req = '0;
    check("tmo_latency", 32'(lat), 32'd20);
    check("tmo_ack", 32'(a), 32'b010);
    check("tmo_err", 32'(e), 32'd1);
    check("tmo_rdata_kept", 32'(rdata), 32'h3C);
    check("tmo_hold", 32'(hold_bad - hb0), 32'd0);
    busy_mode = 0;
    repeat (5) @(negedge clk_8m);
    cart_dout = 8'h61;
    start(1, 1'b0, 16'h0457, 8'h00);
    wait_ack(lat, a, e, ba);
    req = '0;
    check("post_tmo_latency", 32'(lat), 32'd7);
    check("post_tmo_err", 32'(e), 32'd0);
    check("post_tmo_rdata", 32'(rdata), 32'h61);

    // async reset while waiting for busy to fall
    track = 1'b0;
    cart_dout = 8'hC3;
    start(0, 1'b0, 16'h0800, 8'h00);
    begin : find_wf
      for (int n = 0; n < 40; n++) begin
        @(negedge clk_8m);
        if (dbg_state == 3'd3) disable find_wf;
      end
      check("reach_wait_fall", 32'd0, 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_bus_active", 32'(bus_active), 32'd0);
    check("arst_cart_rd", 32'(cart_rd), 32'd0);
    check("arst_cart_wr", 32'(cart_wr), 32'd0);
    check("arst_ack", 32'(ack), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    check("arst_rdata", 32'(rdata), 32'd0);
    @(negedge clk_8m);
    rst_n = 1'b1;
    wait_ack(lat, a, e, ba);
    req = '0;
    check("arst_regrant_latency", 32'(lat), 32'd7);
    check("arst_regrant_ack", 32'(a), 32'b001);
    check("arst_regrant_rdata", 32'(rdata), 32'hC3);

    repeat (2) @(negedge clk_8m);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cart_bus_arbiter.md
Name: cart_bus_arbiter

Overview:
- Shares the single cart_iface port (addr/rd/wr/din/dout/busy) between NREQ requesters: startup screen generator, DMG+ splash generator and SPI cart bridge.
- Replaces the static phase-based combinational mux in the top level with a sequenced, handshaked arbiter. Each requester sees a clean req/ack transaction interface.
- Supports per-requester enable masking, fixed-priority arbitration (optional round-robin) and a bus-timeout watchdog.

Parameters:
- NREQ, 3, number of requesters; index 0 is highest priority.
- TIMEOUT, 255, max clk_8m cycles a transaction may stay outstanding before it is forcibly terminated; 8-bit counter, range 1..255.

Ports:
- clk_8m  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester transaction request, level
- req_wr  in  NREQ  1=write, 0=read; sampled at grant
- req_addr  in  16*NREQ  packed addresses, requester i at [16i+15:16i]
- req_wdata  in  8*NREQ  packed write data
- req_mask  in  NREQ  1=requester allowed to win arbitration
- ack  out  NREQ  one-cycle completion pulse to owner
- ack_err  out  1  valid with ack; 1=transaction timed out
- rdata  out  8  read data, valid from ack cycle until next ack
- owner  out  2  index of current/last granted requester
- bus_active  out  1  high from grant until ack
- cart_addr  out  16  to cart_iface addr
- cart_rd  out  1  to cart_iface rd, one-cycle pulse
- cart_wr  out  1  to cart_iface wr, one-cycle pulse
- cart_din  out  8  to cart_iface din
- cart_dout  in  8  from cart_iface dout
- cart_busy  in  1  from cart_iface busy

Behaviour:
- Reset (async, rst_n=0): state IDLE. ack=0, ack_err=0, rdata=0, owner=0, bus_active=0, cart_rd=0, cart_wr=0, cart_addr=0, cart_din=0, timeout counter=0.
- Eligible set = req & req_mask.
- IDLE:
  - If eligible≠0: pick the winner (lowest index), then latch owner, req_addr slice, req_wdata slice and req_wr into registers.
  - bus_active=1; go to ISSUE.
  - Arbitration decision and latch happen in the same cycle.
- ISSUE, one cycle: cart_rd=!wr_latched or cart_wr=wr_latched, exactly one pulse. cart_addr/cart_din driven from latches, stable for the whole transaction. Go to WAIT_RISE.
- WAIT_RISE:
  - cart_busy=1 → WAIT_FALL.
  - If busy does not rise within 2 cycles, the transaction counts as already complete → DONE. This covers zero-wait responders.
- WAIT_FALL: cart_busy=0 → DONE.
- DONE, one cycle:
  - ack[owner]=1.
  - For reads, rdata<=cart_dout sampled on the DONE entry edge (first cycle busy low). Writes leave rdata unchanged.
  - bus_active<=0; back to IDLE.
- Throughput: minimum latency grant→ack is 4 cycles. No back-to-back issue: one IDLE cycle between transactions.
- Timeout:
  - Counter clears at grant and increments each cycle in ISSUE/WAIT_RISE/WAIT_FALL.
  - Reaching TIMEOUT → DONE with ack_err=1. rdata is not updated on a timed-out read.
- Requester rules:
  - Must hold req, addr, wdata and wr stable until ack.
  - Dropping req after grant does not abort; ack still pulses.
  - Dropping req before grant simply removes it from the eligible set.
  - A requester may re-assert req on the cycle after ack.
- Simultaneous events:
  - req_mask changes mid-transaction have no effect until the next IDLE.
  - Multiple eligible requesters in IDLE resolve in one cycle.
- Reset mid-transaction: all outputs return to reset values immediately. cart_iface is responsible for its own recovery.
- owner holds its last value after ack, for debug.

Optional Feature:
- Macro CART_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last owner+1) mod NREQ, and the last-owner pointer resets to NREQ-1 so requester 0 wins first after reset.
- Undefined: fixed priority, lowest index wins. No pointer register is synthesized.

Test Plan:
- Single read: req[1]=1, addr 0x0134, cart model busy 3 cycles with dout 0x4E → one cart_rd pulse, cart_addr=0x0134, ack[1] 7 cycles after grant, rdata=0x4E, ack_err=0.
- Write: req[2]=1, wr=1, addr 0x2000, wdata 0x05 → one cart_wr pulse, cart_din=0x05 held through busy, ack[2], rdata unchanged.
- Contention, fixed priority: req=3'b111 held continuously, mask=3'b111 → grant order 0,0,0…. With CART_ARB_RR_EN: 0,1,2,0.
- Masking: req=3'b011, mask=3'b010 → only requester 1 served; requester 0 never acked until mask bit set.
- Timeout: TIMEOUT=20, cart_busy stuck high → ack pulses 20 cycles after grant with ack_err=1, rdata unchanged, next request serviced normally.
- Async reset during WAIT_FALL → cart_rd/cart_wr/bus_active/ack all 0 without a clock edge; after release, pending req[0] is granted afresh.
